// File: rtl/axi_rd_scheduler_pkg.sv
// Shared definitions for the AXI read scheduler.
// Contents:
//   rd_idx_e        requester index carried in the top two AR/R ID bits
//   ar_state_e      AR holding-register state
//   AXI_BURST_INCR  fixed AR burst type
//   rr_next()       round-robin successor over the three requesters
package axi_rd_scheduler_pkg;

  localparam int NUM_REQ = 3;

  // Index 3 is never issued on AR, so an R beat that carries it is a fabric error.
  typedef enum logic [1:0] {
    RD_REQ_IC  = 2'd0,
    RD_REQ_DM  = 2'd1,
    RD_REQ_UC  = 2'd2,
    RD_REQ_BAD = 2'd3
  } rd_idx_e;

  typedef enum logic {
    AR_EMPTY = 1'b0,
    AR_FULL  = 1'b1
  } ar_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Successor modulo 3. Index 3 also maps to 0, so a corrupted pointer recovers.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= RD_REQ_UC) ? RD_REQ_IC : idx + 2'd1;
  endfunction

endpackage

// File: rtl/axi_rd_scheduler_if.sv
// AXI read-address and read-data channels of the tile's single master port.
// master : scheduler side (drives AR, accepts R)
// slave  : fabric side (accepts AR, drives R)
// Signal suffixes are named from the scheduler's point of view.
interface axi_rd_scheduler_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4
);

  logic                  ar_valid_o;
  logic                  ar_ready_i;
  logic [ADDR_WIDTH-1:0] ar_addr_o;
  logic [7:0]            ar_len_o;
  logic [2:0]            ar_size_o;
  logic [ID_WIDTH-1:0]   ar_id_o;
  logic [1:0]            ar_burst_o;

  logic                  r_valid_i;
  logic                  r_ready_o;
  logic [DATA_WIDTH-1:0] r_data_i;
  logic [ID_WIDTH-1:0]   r_id_i;
  logic                  r_last_i;
  logic [1:0]            r_resp_i;

  modport master (
    output ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_id_o, ar_burst_o,
    input  ar_ready_i,
    input  r_valid_i, r_data_i, r_id_i, r_last_i, r_resp_i,
    output r_ready_o
  );

  modport slave (
    input  ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_id_o, ar_burst_o,
    output ar_ready_i,
    output r_valid_i, r_data_i, r_id_i, r_last_i, r_resp_i,
    input  r_ready_o
  );

endinterface

// File: rtl/axi_rd_scheduler_rr_arbiter3.sv
// Three-way round-robin arbiter (combinational).
// ptr       : first requester to consider this cycle
// req       : eligible requesters
// gnt_valid : some requester is granted
// gnt_idx   : granted requester index
module axi_rd_scheduler_rr_arbiter3
  import axi_rd_scheduler_pkg::*;
(
  input  logic [1:0] ptr,
  input  logic [2:0] req,
  output logic       gnt_valid,
  output logic [1:0] gnt_idx
);

  logic [3:0] req_ext;

  // Extra zero bit lets a 2-bit candidate index the vector without a range check.
  assign req_ext = {1'b0, req};

  always_comb begin
    logic [1:0] cand;
    // NOTE: every output gets a default before any branch so no latch is inferred.
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    cand      = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_valid && req_ext[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
      cand = rr_next(cand);
    end
  end

endmodule

// File: rtl/axi_rd_scheduler.sv
// Read-side scheduler: shares the AR channel between iCache refill (0),
// dCache miss-read (1) and dCache uncached read (2), tags each AR with the
// requester index in the top two ID bits and steers R beats back by that index.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_*               per-requester AR request (valid/ready/addr/len/size/id)
//   resp_*              R beats steered to requesters (data/id/last/err shared)
//   axi                 AXI AR + R channels (master modport)
//   id_err_o            sticky: an R beat with requester index 3 was seen
module axi_rd_scheduler
  import axi_rd_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [2:0]                      req_valid_i,
  output logic [2:0]                      req_ready_o,
  input  logic [2:0][ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [2:0][7:0]                 req_len_i,
  input  logic [2:0][2:0]                 req_size_i,
  input  logic [2:0][ID_WIDTH-3:0]        req_id_i,
  output logic [2:0]                      resp_valid_o,
  input  logic [2:0]                      resp_ready_i,
  output logic [DATA_WIDTH-1:0]           resp_data_o,
  output logic [ID_WIDTH-3:0]             resp_id_o,
  output logic                            resp_last_o,
  output logic                            resp_err_o,
  axi_rd_scheduler_if.master              axi,
  output logic                            id_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam int LID_W = ID_WIDTH - 2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [LID_W-1:0]      id;
  } rd_req_t;

  ar_state_e             state;
  logic [1:0]            rr_ptr;
  logic [2:0][CNT_W-1:0] outst_cnt;
  logic [2:0]            eligible;
  logic [2:0]            inc;
  logic [2:0]            dec;
  logic                  gnt_valid;
  logic [1:0]            gnt_idx;
  logic                  can_load;
  logic                  accept;
  rd_req_t               sel_req;

  logic [1:0]            r_idx;
  logic                  r_bad;
  logic                  r_hs;
  logic [3:0]            ready_ext;
  logic                  unused_resp_lsb;

  // ---------------------------------------------------------------- AR side

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible[k] = req_valid_i[k] && (outst_cnt[k] < CNT_W'(MAX_OUTST));
    end
  end

  axi_rd_scheduler_rr_arbiter3 u_arb (
    .ptr       (rr_ptr),
    .req       (eligible),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // A full register can be overwritten in the same cycle its AR is taken.
  assign can_load = (state == AR_EMPTY) || axi.ar_ready_i;
  // Reset gating keeps req_ready low while rst_i is held, not just after it.
  assign accept      = can_load && gnt_valid && !rst_i;
  assign req_ready_o = accept ? (3'b001 << gnt_idx) : 3'b000;
  assign inc         = req_ready_o & req_valid_i;

  always_comb begin
    case (gnt_idx)
      2'd1:    sel_req = '{addr: req_addr_i[1], len: req_len_i[1], size: req_size_i[1], id: req_id_i[1]};
      2'd2:    sel_req = '{addr: req_addr_i[2], len: req_len_i[2], size: req_size_i[2], id: req_id_i[2]};
      default: sel_req = '{addr: req_addr_i[0], len: req_len_i[0], size: req_size_i[0], id: req_id_i[0]};
    endcase
  end

  // AR holding register. Fields only change on a load, which keeps them stable
  // while ar_valid_o is high and ar_ready_i is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= AR_EMPTY;
      axi.ar_valid_o <= 1'b0;
      axi.ar_addr_o  <= '0;
      axi.ar_len_o   <= '0;
      axi.ar_size_o  <= '0;
      axi.ar_id_o    <= '0;
      rr_ptr         <= 2'd0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      state          <= AR_FULL;
      axi.ar_valid_o <= 1'b1;
      axi.ar_addr_o  <= sel_req.addr;
      axi.ar_len_o   <= sel_req.len;
      axi.ar_size_o  <= sel_req.size;
      axi.ar_id_o    <= {gnt_idx, sel_req.id};
      rr_ptr         <= rr_next(gnt_idx);
    end else if (state == AR_FULL && axi.ar_ready_i) begin
      state          <= AR_EMPTY;
      axi.ar_valid_o <= 1'b0;
    end
  end

  assign axi.ar_burst_o = AXI_BURST_INCR;

  // ---------------------------------------------------------------- R side

  assign r_idx     = axi.r_id_i[ID_WIDTH-1 -: 2];
  assign r_bad     = (r_idx == RD_REQ_BAD);
  // Index 3 has no requester behind it, so its beats are always accepted and dropped.
  assign ready_ext = {1'b1, resp_ready_i};
  assign axi.r_ready_o = ready_ext[r_idx];
  assign r_hs      = axi.r_valid_i && axi.r_ready_o;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      resp_valid_o[k] = axi.r_valid_i && (r_idx == 2'(k));
      // Guarding zero keeps a stray last beat from wrapping the counter.
      dec[k] = r_hs && axi.r_last_i && (r_idx == 2'(k)) && (outst_cnt[k] != '0);
    end
  end

  assign resp_data_o     = axi.r_data_i;
  assign resp_id_o       = axi.r_id_i[LID_W-1:0];
  assign resp_last_o     = axi.r_last_i;
  assign resp_err_o      = axi.r_resp_i[1];
  assign unused_resp_lsb = axi.r_resp_i[0];

  // Outstanding-burst counters: simultaneous issue and completion cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (inc[k] && !dec[k]) begin
          outst_cnt[k] <= outst_cnt[k] + CNT_W'(1);
        end else if (dec[k] && !inc[k]) begin
          outst_cnt[k] <= outst_cnt[k] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_err_o <= 1'b0;
    end else if (r_hs && r_bad) begin
      id_err_o <= 1'b1;
    end
  end

endmodule
